// File: rtl/reg_file.sv
// 32-entry register file with same-cycle writeback bypass and a busy-bit
// scoreboard that flags source operands still waiting on an in-flight producer.
module reg_file #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        src1,
  input  logic [4:0]        src2,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  input  logic              WB_EN_in,
  input  logic [4:0]        WB_Dest,
  input  logic [DATA_W-1:0] WB_Value,
  input  logic              issue_en,
  input  logic [4:0]        issue_dest,
  output logic              hazard,
  output logic [5:0]        busy_cnt
);

  // Strobe semantics: issue_en and WB_EN_in are single-cycle qualifiers with no
  // back-pressure; each is consumed on the rising edge where it is high.
  // Destination 0 is ignored on both. issue_en is never gated by hazard here.

  logic [DATA_W-1:0] regs [32];
  logic [31:0]       busy;
  logic [31:0]       busy_next;
  logic              wr_en;
  logic              set_en;
  logic              hz1;
  logic              hz2;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  assign wr_en  = WB_EN_in && (WB_Dest != 5'd0);
  assign set_en = issue_en && (issue_dest != 5'd0);

  // Register storage; R0 stays at its reset value of zero forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_en && (WB_Dest == 5'(i))) begin
          regs[i] <= WB_Value;
        end
      end
    end
  end

  // Clear first, then set, so a same-register collision leaves the newer
  // producer pending.
  always_comb begin
    busy_next = busy;
    if (wr_en) begin
      busy_next[WB_Dest] = 1'b0;
    end
    if (set_en) begin
      busy_next[issue_dest] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= popcount(busy_next);
    end
  end

  // Read ports with writeback bypass.
  always_comb begin
    reg1 = '0;
    reg2 = '0;
    if (src1 != 5'd0) begin
      reg1 = (wr_en && (WB_Dest == src1)) ? WB_Value : regs[src1];
    end
    if (src2 != 5'd0) begin
      reg2 = (wr_en && (WB_Dest == src2)) ? WB_Value : regs[src2];
    end
  end

  // A pending operand whose producer is writing back this cycle is not a hazard.
  always_comb begin
    hz1    = (src1 != 5'd0) && busy[src1] && !(WB_EN_in && (WB_Dest == src1));
    hz2    = (src2 != 5'd0) && busy[src2] && !(WB_EN_in && (WB_Dest == src2));
    hazard = hz1 || hz2;
  end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: hand-derived vector table, reset/saturation sequences,
// and randomized traffic checked against an array-based reference model.
module tb_reg_file;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [4:0]        src1, src2;
  logic [DATA_W-1:0] reg1, reg2;
  logic              wb_en;
  logic [4:0]        wb_dest;
  logic [DATA_W-1:0] wb_val;
  logic              issue_en;
  logic [4:0]        issue_dest;
  logic              hazard;
  logic [5:0]        busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] m_regs [32];
  logic [31:0]       m_busy;

  reg_file #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .src1      (src1),
    .src2      (src2),
    .reg1      (reg1),
    .reg2      (reg2),
    .WB_EN_in  (wb_en),
    .WB_Dest   (wb_dest),
    .WB_Value  (wb_val),
    .issue_en  (issue_en),
    .issue_dest(issue_dest),
    .hazard    (hazard),
    .busy_cnt  (busy_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_val;
    logic        iss_en;
    logic [4:0]  iss_dest;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] e_reg1;
    logic [31:0] e_reg2;
    logic        e_hz;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wv,
                       input logic ie, input logic [4:0] id,
                       input logic [4:0] s1, input logic [4:0] s2);
    wb_en = we; wb_dest = wd; wb_val = wv;
    issue_en = ie; issue_dest = id;
    src1 = s1; src2 = s2;
  endtask

  // reference model
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] s);
    if (s == 0) return '0;
    if (wb_en && wb_dest == s) return wb_val;
    return m_regs[s];
  endfunction

  function automatic logic m_hazard();
    logic h;
    h = 1'b0;
    if (src1 != 0 && m_busy[src1] && !(wb_en && wb_dest == src1)) h = 1'b1;
    if (src2 != 0 && m_busy[src2] && !(wb_en && wb_dest == src2)) h = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] m_count();
    return 32'($countones(m_busy));
  endfunction

  // advance one edge, updating the model from the inputs applied this cycle
  task automatic cycle();
    for (int r = 1; r < 32; r++) begin
      if (issue_en && issue_dest == r)  m_busy[r] = 1'b1;
      else if (wb_en && wb_dest == r)   m_busy[r] = 1'b0;
      if (wb_en && wb_dest == r)        m_regs[r] = wb_val;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_reg1"}, reg1, m_read(src1));
    chk({tag, "_reg2"}, reg2, m_read(src2));
    chk({tag, "_hazard"}, {31'd0, hazard}, {31'd0, m_hazard()});
  endtask

  initial begin
    logic [4:0] perm [31];
    logic [4:0] tmp;
    int j;

    tbl[0]  = '{1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd3, 32'h12345678, 32'h12345678, 1'b0, 6'd0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h12345678, 32'h0,        1'b0, 6'd0};
    tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 6'd0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd3, 5'd7, 32'h12345678, 32'h0,        1'b0, 6'd1};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h0,        1'b1, 6'd1};
    tbl[5]  = '{1'b1, 5'd7, 32'h000000A5, 1'b0, 5'd0, 5'd7, 5'd7, 32'hA5,       32'hA5,       1'b0, 6'd0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd3, 32'h0,        32'h12345678, 1'b0, 6'd1};
    tbl[7]  = '{1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd9, 5'd0, 32'h99,       32'h0,        1'b0, 6'd1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd7, 32'h99,       32'hA5,       1'b1, 6'd1};
    tbl[9]  = '{1'b1, 5'd9, 32'h00000055, 1'b1, 5'd4, 5'd4, 5'd9, 32'h0,        32'h55,       1'b0, 6'd1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd9, 32'h0,        32'h55,       1'b1, 6'd1};

    // reset state
    rst = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd5, 5'd9);
    model_reset();
    #7;
    chk("rst_reg1", reg1, 32'h0);
    chk("rst_reg2", reg2, 32'h0);
    chk("rst_cnt", {26'd0, busy_cnt}, 32'h0);
    chk("rst_hazard", {31'd0, hazard}, 32'h0);
    #5 rst = 1'b1;
    @(posedge clk);
    #1;

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].wb_en, tbl[i].wb_dest, tbl[i].wb_val, tbl[i].iss_en, tbl[i].iss_dest,
            tbl[i].s1, tbl[i].s2);
      #1;
      chk($sformatf("tbl%0d_reg1", i), reg1, tbl[i].e_reg1);
      chk($sformatf("tbl%0d_reg2", i), reg2, tbl[i].e_reg2);
      chk($sformatf("tbl%0d_hazard", i), {31'd0, hazard}, {31'd0, tbl[i].e_hz});
      cycle();
      chk($sformatf("tbl%0d_cnt", i), {26'd0, busy_cnt}, {26'd0, tbl[i].e_cnt});
    end

    // asynchronous reset mid-cycle discards same-cycle write and issue
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5, 5'd6);
    cycle();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd5, 5'd6);
    #1;
    chk("pre_rst_reg1", reg1, 32'hDEADBEEF);
    chk("pre_rst_hazard", {31'd0, hazard}, 32'h1);
    drive(1'b1, 5'd6, 32'h11111111, 1'b1, 5'd6, 5'd5, 5'd6);
    #1 rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_reg1", reg1, 32'h0);
    chk("mid_rst_cnt", {26'd0, busy_cnt}, 32'h0);
    chk("mid_rst_hazard", {31'd0, hazard}, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd5, 5'd6);
    #1 rst = 1'b1;
    #1;
    chk("post_rst_r6", reg2, 32'h0);
    chk("post_rst_cnt", {26'd0, busy_cnt}, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd6, 32'hCAFEF00D, 1'b1, 5'd6, 5'd6, 5'd6);
    cycle();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd6, 5'd0);
    #1;
    chk("first_edge_r6", reg1, 32'hCAFEF00D);
    chk("first_edge_cnt", {26'd0, busy_cnt}, 32'h1);
    chk("first_edge_hazard", {31'd0, hazard}, 32'h1);
    drive(1'b1, 5'd6, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle();
    chk("drain_cnt", {26'd0, busy_cnt}, 32'h0);

    // saturation: issue R1..R31, then retire in shuffled order
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, '0, 1'b1, 5'(i), 5'd0, 5'd0);
      cycle();
      chk($sformatf("sat_up%0d", i), {26'd0, busy_cnt}, 32'(i));
    end
    for (int i = 0; i < 31; i++) perm[i] = 5'(i + 1);
    for (int i = 30; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int k = 0; k < 31; k++) begin
      drive(1'b1, perm[k], $urandom, 1'b0, 5'd0, perm[k], 5'($urandom_range(0, 31)));
      #1;
      chk_model($sformatf("sat_dn%0d", k));
      cycle();
      chk($sformatf("sat_dn%0d_cnt", k), {26'd0, busy_cnt}, 32'(30 - k));
    end

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
            $urandom,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 9)),
            5'($urandom_range(0, 31)));
      #1;
      chk_model("rnd");
      cycle();
      chk("rnd_cnt", {26'd0, busy_cnt}, m_count());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port src1, input, 5, read address port 1.
REQ-005 The block SHALL have port src2, input, 5, read address port 2.
REQ-006 The block SHALL have port reg1, output, DATA_W, read data for src1.
REQ-007 The block SHALL have port reg2, output, DATA_W, read data for src2.
REQ-008 The block SHALL have port WB_EN_in, input, 1, writeback write enable.
REQ-009 The block SHALL have port WB_Dest, input, 5, writeback destination register.
REQ-010 The block SHALL have port WB_Value, input, DATA_W, writeback data.
REQ-011 The block SHALL have port issue_en, input, 1, an instruction with a register write leaves ID this cycle.
REQ-012 The block SHALL have port issue_dest, input, 5, destination of that issuing instruction.
REQ-013 The block SHALL have port hazard, output, 1, a source operand is pending writeback.
REQ-014 The block SHALL have port busy_cnt, output, 6, number of registers currently pending.

Function
REQ-015 Storage SHALL be 32 registers of DATA_W bits; R0 reads 0 always and is never written.
REQ-016 A write SHALL occur on the rising clk edge when WB_EN_in=1 and WB_Dest!=0; WB_EN_in=1 with WB_Dest=0 SHALL be a no-op.
REQ-017 Reads SHALL be combinational, 0-cycle latency: reg1=regs[src1], reg2=regs[src2].
REQ-018 Bypass: when WB_EN_in=1, WB_Dest!=0, and WB_Dest==srcN, regN SHALL return WB_Value in the same cycle; both ports bypass independently and may bypass simultaneously.
REQ-019 Scoreboard: a 32-bit busy vector SHALL exist; bit 0 SHALL be constantly 0.
REQ-020 On a rising edge with issue_en=1 and issue_dest!=0, busy[issue_dest] SHALL be set.
REQ-021 On a rising edge with WB_EN_in=1 and WB_Dest!=0, busy[WB_Dest] SHALL be cleared.
REQ-022 Same edge, same register set and clear: set SHALL win (bit remains 1, newer producer pending).
REQ-023 Same edge, different registers: set and clear SHALL both take effect.
REQ-024 Clear of a non-busy register SHALL leave it 0 with no side effect; set of an already-busy register SHALL leave it 1.
REQ-025 hazard SHALL be combinational: 1 iff for N in {1,2}, srcN!=0, busy[srcN]=1, and NOT (WB_EN_in=1 and WB_Dest==srcN).
REQ-026 The block SHALL NOT gate issue_en with hazard; the stall decision belongs to the ID/hazard logic.
REQ-027 busy_cnt SHALL be the registered population count of busy, consistent with busy after every edge (range 0..31).
REQ-028 Register contents SHALL be independent of scoreboard state: a writeback writes data whether or not the bit was busy.

Reset
REQ-029 While rst=0, all 32 registers, busy, and busy_cnt SHALL be 0 immediately, without a clock edge.
REQ-030 Reset asserted mid-operation SHALL discard any same-cycle write or issue; no write SHALL occur on an edge while rst=0.
REQ-031 After rst rises, the first rising edge SHALL perform normal writes/sets.

Verification
REQ-032 Reset: drive rst=0 mid-cycle after writing R5=0xDEADBEEF -> reg1 with src1=5 reads 0 at once, busy_cnt=0, hazard=0.
REQ-033 Write/read/bypass: WB_EN_in=1, WB_Dest=3, WB_Value=0x12345678, src1=src2=3 -> both reads 0x12345678 before the edge; after the edge with WB_EN_in=0 still 0x12345678.
REQ-034 R0: WB_EN_in=1, WB_Dest=0, WB_Value=0xFFFFFFFF; issue_en=1, issue_dest=0 -> reg1 (src1=0)=0, busy_cnt=0, hazard=0.
REQ-035 Scoreboard: issue R7 -> next cycle src2=7 gives hazard=1, busy_cnt=1; writeback R7=0xA5 -> same cycle hazard=0, reg2=0xA5; next cycle busy_cnt=0.
REQ-036 Collision: R9 busy; same edge issue_dest=9 and WB_Dest=9 -> after edge busy[9]=1, busy_cnt=1, R9 holds WB_Value, hazard=1 for src1=9.
REQ-037 Saturation: issue R1..R31 on consecutive cycles -> busy_cnt=31; writeback all in any order -> busy_cnt decrements by 1 per edge to 0.
